channel_scanner: RTL

CHANNEL_SCANNER -- requirements
Module: channel_scanner

---
 rtl/channel_scanner.sv | 77 +++++++
 1 files changed

// File: rtl/channel_scanner.sv
// channel_scanner: steps a registered select across a 2**N:1 mux, assembling one word per start.
// Define SCAN_PARITY_EN to add a registered parity output (XOR of data) that updates with data.
module channel_scanner #(
  parameter int N = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            y,
  output logic [N-1:0]    s,
  output logic [2**N-1:0] data,
  output logic            valid,
  input  logic            ready,
`ifdef SCAN_PARITY_EN
  output logic            parity,
`endif
  output logic            busy
);

  localparam int            CH   = 2**N;
  localparam logic [N-1:0]  LAST = N'(CH - 1);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t        state, state_nx;
  logic [CH-1:0] shadow, shadow_nx;
  logic          last_ch;

  assign last_ch = (s == LAST);

  always_comb begin
    state_nx     = state;
    shadow_nx    = shadow;
    shadow_nx[s] = y;
    busy         = 1'b0;
    valid        = 1'b0;
    case (state)
      IDLE: if (start) state_nx = SCAN;
      SCAN: begin
        busy = 1'b1;
        if (last_ch) state_nx = HOLD;
      end
      HOLD: begin
        valid = 1'b1;
        if (ready) state_nx = start ? SCAN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // s is only ever advanced in SCAN and wraps to 0 on the final channel,
  // so it is already 0 whenever a new scan begins.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      s      <= '0;
      shadow <= '0;
      data   <= '0;
`ifdef SCAN_PARITY_EN
      parity <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (state == SCAN) begin
        shadow <= shadow_nx;
        s      <= s + N'(1);
        if (last_ch) begin
          data   <= shadow_nx;
`ifdef SCAN_PARITY_EN
          parity <= ^shadow_nx;
`endif
        end
      end
    end
  end

endmodule
